// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encodings and constants for the serial add scheduler
package serial_add_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int NUM_REQ = 2;
  localparam logic LAST_ID_RST = 1'b1;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder slice
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin two-requester bit-serial adder over one shared full_adder slice
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               cin0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               cin1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic last_id, grant, fa_s, fa_co, carry, c_msb_in;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  assign grant = (&req_valid) ? ~last_id : req_valid[1];
  assign req_ready = (state == ST_IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : '0;
  assign rsp_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  full_adder u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(fa_s), .cout(fa_co));
  // Result registers are loaded on the final RUN cycle so they survive the next operation's RUN phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_id  <= LAST_ID_RST;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (|req_valid) begin
        state   <= ST_RUN;
        a_sh    <= grant ? a1 : a0;
        b_sh    <= grant ? b1 : b0;
        carry   <= grant ? cin1 : cin0;
        rsp_id  <= grant;
        last_id <= grant;
        cnt     <= '0;
      end
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 2)) c_msb_in <= fa_co;
      if (cnt == CW'(WIDTH - 1)) begin
        state    <= ST_DONE;
        rsp_sum  <= {fa_s, sum_sh[WIDTH-1:1]};
        rsp_cout <= fa_co;
        rsp_ovf  <= c_msb_in ^ fa_co;
      end
    end else if (state == ST_DONE) begin
      if (rsp_ready) state <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
